// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: one outstanding imem request, a one-entry decode
// holding register, and PC advance/redirect. Optional fault reporting: IFETCH_FAULT_EN.
module ifetch_ctrl #(
    parameter int XLEN    = 32,
    parameter int PC_STEP = 4
) (
    input  logic            clk,
    input  logic            areset,
    input  logic [XLEN-1:0] pc,
    output logic            pc_load,
    output logic [XLEN-1:0] next_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            imem_rsp_ready,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic            id_fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] id_instr_q, id_instr_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic            id_fault_q, id_fault_d;

    logic            misalign;
    logic            rsp_fault;

`ifdef IFETCH_FAULT_EN
    assign misalign      = |pc[1:0];
    assign rsp_fault     = imem_rsp_err;
    assign imem_req_addr = pc;
`else
    logic unused_rsp_err;
    assign unused_rsp_err = imem_rsp_err;
    assign misalign       = 1'b0;
    assign rsp_fault      = 1'b0;
    assign imem_req_addr  = {pc[XLEN-1:2], 2'b00};
`endif

    assign id_instr = id_instr_q;
    assign id_pc    = id_pc_q;
    assign id_fault = id_fault_q;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q    <= S_IDLE;
            id_instr_q <= '0;
            id_pc_q    <= '0;
            id_fault_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_fault_q <= id_fault_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        id_instr_d     = id_instr_q;
        id_pc_d        = id_pc_q;
        id_fault_d     = id_fault_q;
        imem_req_valid = 1'b0;
        imem_rsp_ready = 1'b0;
        id_valid       = 1'b0;
        pc_load        = 1'b0;
        next_pc        = pc + XLEN'(PC_STEP);

        case (state_q)
            S_IDLE: state_d = S_REQ;

            S_REQ: begin
                if (misalign) begin
                    // Misaligned PC never reaches memory; report it as a held fault.
                    if (!redirect) begin
                        state_d    = S_HOLD;
                        id_instr_d = '0;
                        id_pc_d    = pc;
                        id_fault_d = 1'b1;
                    end
                end else begin
                    imem_req_valid = 1'b1;
                    if (redirect)
                        state_d = imem_req_ready ? S_DRAIN : S_REQ;
                    else if (imem_req_ready)
                        state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                imem_rsp_ready = 1'b1;
                if (redirect) begin
                    state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
                end else if (imem_rsp_valid) begin
                    state_d    = S_HOLD;
                    id_instr_d = rsp_fault ? '0 : imem_rsp_data;
                    id_pc_d    = pc;
                    id_fault_d = rsp_fault;
                    pc_load    = !rsp_fault;
                end
            end

            S_HOLD: begin
                // A redirect kills the held entry in the same cycle, so no handshake.
                id_valid = !redirect;
                if (redirect || id_ready)
                    state_d = S_REQ;
            end

            S_DRAIN: begin
                imem_rsp_ready = 1'b1;
                if (imem_rsp_valid)
                    state_d = S_REQ;
            end

            default: state_d = S_IDLE;
        endcase

        if (redirect && areset) begin
            pc_load = 1'b1;
            next_pc = redirect_pc;
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Randomized bench for ifetch_ctrl: a transaction-level model tracks which PC decode
// must see next and a simple memory serves one request at a time.
module tb_ifetch_ctrl;

`ifdef IFETCH_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        areset;
    logic [31:0] pc;
    logic        pc_load;
    logic [31:0] next_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        imem_rsp_ready;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_fault;

    ifetch_ctrl dut (
        .clk(clk), .areset(areset), .pc(pc), .pc_load(pc_load), .next_pc(next_pc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .imem_rsp_ready(imem_rsp_ready), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc), .id_fault(id_fault)
    );

    always #5 clk = ~clk;

    // The PC register the controller drives
    always @(posedge clk or negedge areset) begin
        if (!areset)      pc <= 32'h0;
        else if (pc_load) pc <= next_pc;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h00500093 ^ (a * 32'h9E3779B1);
    endfunction

    // stimulus knobs
    int          k_rdy, k_lat_min, k_lat_max, k_idr, k_redir, k_err;
    bit          f_redir;
    logic [31:0] f_tgt;
    bit          ovr_en;
    logic [31:0] ovr_data;

    // memory and reference model
    bit          mem_busy, mem_orphan, mem_err;
    int          mem_lat;
    logic [31:0] mem_data;
    logic [31:0] exp_pc;
    bit          last_err;
    int          delivered;
    bit          prev_hold;
    logic [31:0] prev_instr, prev_pc;
    bit          last_req_fire, last_id_fire;
    logic [31:0] last_req_addr;

    task automatic model_reset();
        mem_busy   = 1'b0;
        mem_orphan = 1'b0;
        mem_err    = 1'b0;
        mem_lat    = 0;
        exp_pc     = 32'h0;
        last_err   = 1'b0;
        prev_hold  = 1'b0;
    endtask

    task automatic step();
        bit req_fire, rsp_fire, id_fire, mis, flt, exp_load;
        @(negedge clk);
        imem_req_ready = !mem_busy && (int'($urandom_range(99)) < k_rdy);
        imem_rsp_valid = mem_busy && (mem_lat == 0);
        imem_rsp_data  = imem_rsp_valid ? mem_data : $urandom;
        imem_rsp_err   = imem_rsp_valid ? mem_err : 1'($urandom_range(1));
        id_ready       = int'($urandom_range(99)) < k_idr;
        if (f_redir) begin
            redirect    = 1'b1;
            redirect_pc = f_tgt;
            f_redir     = 1'b0;
        end else if (int'($urandom_range(99)) < k_redir) begin
            redirect    = 1'b1;
            redirect_pc = $urandom & 32'hFFFF_FFFC;
        end else begin
            redirect    = 1'b0;
        end
        #1;
        req_fire = imem_req_valid && imem_req_ready;
        rsp_fire = imem_rsp_valid && imem_rsp_ready;
        id_fire  = id_valid && id_ready;

        if (imem_rsp_valid) chk("rsp_ready", 32'(imem_rsp_ready), 1);
        if (mem_busy)       chk("one_outstanding", 32'(imem_req_valid), 0);
        if (prev_hold) begin
            chk("hold_instr", id_instr, prev_instr);
            chk("hold_pc", id_pc, prev_pc);
        end
        if (req_fire && !redirect)
            chk("req_addr", imem_req_addr, FAULT_EN ? exp_pc : (exp_pc & 32'hFFFF_FFFC));
        if (id_fire) begin
            mis = FAULT_EN && (exp_pc[1:0] != 2'b00);
            flt = mis || (FAULT_EN && last_err);
            chk("id_pc", id_pc, exp_pc);
            chk("id_fault", 32'(id_fault), 32'(flt));
            chk("id_instr", id_instr, flt ? 32'h0 : mem_word(exp_pc));
            if (!flt) exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        if (redirect) begin
            chk("redir_load", 32'(pc_load), 1);
            chk("redir_pc", next_pc, redirect_pc);
            exp_pc = redirect_pc;
        end else if (rsp_fire && !mem_orphan) begin
            exp_load = !(FAULT_EN && mem_err);
            chk("rsp_load", 32'(pc_load), 32'(exp_load));
            if (exp_load) chk("seq_pc", next_pc, pc + 32'd4);
        end else begin
            chk("no_load", 32'(pc_load), 0);
        end

        if (rsp_fire) begin
            if (!mem_orphan && !redirect) last_err = mem_err;
            mem_busy   = 1'b0;
            mem_orphan = 1'b0;
        end else if (mem_busy) begin
            if (redirect) mem_orphan = 1'b1;
            if (mem_lat > 0) mem_lat--;
        end
        if (req_fire) begin
            mem_busy   = 1'b1;
            mem_orphan = redirect;
            mem_lat    = int'($urandom_range(k_lat_max, k_lat_min));
            mem_data   = ovr_en ? ovr_data : mem_word(imem_req_addr);
            ovr_en     = 1'b0;
            mem_err    = int'($urandom_range(99)) < k_err;
        end
        prev_hold     = id_valid && !id_ready;
        prev_instr    = id_instr;
        prev_pc       = id_pc;
        last_req_fire = req_fire;
        last_req_addr = imem_req_addr;
        last_id_fire  = id_fire;
    endtask

    task automatic wait_req(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 15 && !ok; i++) begin
            step();
            ok = last_req_fire;
        end
        chk(tag, 32'(ok), 1);
    endtask

    task automatic knobs(input int rdy, input int lmin, input int lmax, input int idr,
                         input int rd, input int er);
        k_rdy = rdy; k_lat_min = lmin; k_lat_max = lmax;
        k_idr = idr; k_redir = rd; k_err = er;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bit found;
        areset = 1'b0; redirect = 1'b1; redirect_pc = 32'h123;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        imem_rsp_err = 1'b0; id_ready = 1'b0;
        f_redir = 1'b0; f_tgt = 32'h0; ovr_en = 1'b0; ovr_data = 32'h0;
        delivered = 0; last_req_fire = 1'b0; last_id_fire = 1'b0; last_req_addr = 32'h0;
        model_reset();
        knobs(100, 0, 0, 100, 0, 0);

        // reset state, even with a redirect pending
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 0);
        chk("rst_rsp_ready", 32'(imem_rsp_ready), 0);
        chk("rst_id_valid", 32'(id_valid), 0);
        chk("rst_pc_load", 32'(pc_load), 0);
        chk("rst_id_instr", id_instr, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_id_fault", 32'(id_fault), 0);
        redirect = 1'b0;

        // IDLE cycle, then back-to-back fetches at 0,4,8,12
        @(negedge clk);
        areset = 1'b1;
        #1;
        chk("idle_req_valid", 32'(imem_req_valid), 0);
        step();
        chk("first_req_valid", 32'(imem_req_valid), 1);
        chk("first_req_addr", imem_req_addr, 32'h0);
        step();
        chk("first_load", 32'(pc_load), 1);
        chk("first_next_pc", next_pc, 32'h4);
        step();
        chk("first_id_valid", 32'(id_valid), 1);
        chk("first_id_instr", id_instr, 32'h00500093);
        chk("first_id_pc", id_pc, 32'h0);
        repeat (9) step();
        chk("b2b_count", 32'(delivered), 4);

        // decode stalls for 5 cycles in HOLD
        k_idr = 0;
        repeat (3) step();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            chk("stall_id_valid", 32'(id_valid), 1);
            chk("stall_no_req", 32'(imem_req_valid), 0);
        end
        k_idr = 100;
        step();
        chk("stall_release", 32'(last_id_fire), 1);
        step();
        chk("after_stall_req", 32'(last_req_fire), 1);
        chk("after_stall_addr", last_req_addr, 32'd20);

        // redirect in WAIT with slow memory: orphan 0xDEADBEEF is drained
        k_lat_min = 3; k_lat_max = 3;
        ovr_en = 1'b1; ovr_data = 32'hDEADBEEF;
        wait_req("drain_setup");
        f_redir = 1'b1; f_tgt = 32'h100;
        step();
        chk("drain_no_rsp_yet", 32'(imem_rsp_valid), 0);
        k_lat_min = 0; k_lat_max = 0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            chk("drain_no_id", 32'(id_valid), 0);
            found = last_req_fire;
        end
        chk("drain_req_seen", 32'(found), 1);
        chk("drain_req_addr", last_req_addr, 32'h100);

        // redirect coinciding with the response
        f_redir = 1'b1; f_tgt = 32'h200;
        step();
        chk("same_rsp_valid", 32'(imem_rsp_valid), 1);
        chk("same_load", 32'(pc_load), 1);
        chk("same_next_pc", next_pc, 32'h200);
        wait_req("same_req_seen");
        chk("same_req_addr", last_req_addr, 32'h200);

        // asynchronous reset while waiting for memory
        k_lat_min = 3; k_lat_max = 3;
        wait_req("arst_setup");
        step();
        #2 areset = 1'b0;
        #1;
        chk("arst_req_valid", 32'(imem_req_valid), 0);
        chk("arst_rsp_ready", 32'(imem_rsp_ready), 0);
        chk("arst_id_valid", 32'(id_valid), 0);
        chk("arst_pc_load", 32'(pc_load), 0);
        chk("arst_id_instr", id_instr, 0);
        chk("arst_id_pc", id_pc, 0);
        model_reset();
        k_lat_min = 0; k_lat_max = 0;
        repeat (2) @(negedge clk);
        areset = 1'b1;
        #1;
        chk("arst_idle", 32'(imem_req_valid), 0);
        step();
        chk("arst_restart_req", 32'(imem_req_valid), 1);
        chk("arst_restart_addr", imem_req_addr, 32'h0);

        // PC wrap past 0xFFFFFFFC
        f_redir = 1'b1; f_tgt = 32'hFFFF_FFF8;
        repeat (20) step();
        chk("wrap_passed", 32'(exp_pc < 32'h100), 1);

`ifdef IFETCH_FAULT_EN
        // misaligned PC becomes a held fault without a memory request
        f_redir = 1'b1; f_tgt = 32'h6;
        found = 1'b0;
        for (int i = 0; i < 15 && !found; i++) begin
            step();
            if (pc == 32'h6 && !redirect) chk("mis_no_req", 32'(imem_req_valid), 0);
            found = last_id_fire;
        end
        chk("mis_fault_seen", 32'(found), 1);
        f_redir = 1'b1; f_tgt = 32'h40;
        step();
`endif

        // bus error on the response
        k_err = 100;
        d0 = delivered;
        for (int i = 0; i < 15 && delivered == d0; i++) step();
        chk("err_delivered", 32'(delivered > d0), 1);
        k_err = 0;

        // random traffic
        knobs(70, 0, 3, 60, 6, 10);
        d0 = delivered;
        repeat (3000) step();
        chk("random_progress", 32'(delivered > d0 + 100), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction-fetch controller on the consumer side of the program counter register.
- Reads the current PC, issues a request/response transaction to instruction memory, and holds the returned instruction for decode under a valid/ready handshake.
- Drives the PC's load and next-value inputs: sequential advance (pc+4) on each completed fetch, and redirect to a branch/trap target on request.

Parameters:
- XLEN, 32, width of PC, addresses and instruction word.
- PC_STEP, 4, byte increment applied to the PC after a successful fetch.

Ports:
- clk  in  1  system clock, rising edge.
- areset  in  1  asynchronous active-low reset (0 = reset).
- pc  in  XLEN  current program counter from the PC register.
- pc_load  out  1  PC load enable (combinational).
- next_pc  out  XLEN  value loaded into the PC when pc_load=1 (combinational).
- redirect  in  1  branch/trap redirect request, single-cycle pulse.
- redirect_pc  in  XLEN  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  XLEN  fetch address.
- imem_req_ready  in  1  memory accepts the request.
- imem_rsp_valid  in  1  response valid.
- imem_rsp_data  in  XLEN  instruction word.
- imem_rsp_err  in  1  bus error on the response.
- imem_rsp_ready  out  1  controller accepts the response.
- id_valid  out  1  instruction available to decode.
- id_ready  in  1  decode consumes the instruction.
- id_instr  out  XLEN  held instruction.
- id_pc  out  XLEN  address of the held instruction.
- id_fault  out  1  the held entry is a fetch fault.

Behaviour:
- Reset (areset=0, asynchronous):
  - State = IDLE.
  - id_instr, id_pc and id_fault cleared to 0.
  - imem_req_valid, imem_rsp_ready, id_valid and pc_load are all 0.
  - Reset mid-transaction abandons any outstanding request. Memory is reset by the same signal.
- FSM states: IDLE, REQ, WAIT, HOLD, DRAIN.
  - IDLE: lasts one cycle after reset release, then REQ. No outputs asserted.
  - REQ: imem_req_valid=1, imem_req_addr=pc. When imem_req_ready=1, move to WAIT.
  - WAIT: imem_rsp_ready=1. When imem_rsp_valid=1:
    - Register id_instr=imem_rsp_data, id_pc=pc, and id_fault.
    - Assert pc_load=1 with next_pc=pc+PC_STEP (modulo 2^XLEN, wraps at 0xFFFFFFFC to 0).
    - Move to HOLD.
  - HOLD: id_valid=1. When id_ready=1, move to REQ. Fetch-to-decode latency is therefore request-accept cycle + memory latency + 1.
  - DRAIN: imem_rsp_ready=1. One orphaned response is discarded, then REQ. No PC update and no id_valid.
- Redirect has priority over all other events in every state except IDLE and DRAIN. It forces pc_load=1 and next_pc=redirect_pc.
  - REQ, request not accepted: go to REQ. The new PC is presented the following cycle.
  - REQ, request accepted in the same cycle: go to DRAIN.
  - WAIT, response arriving in the same cycle: response discarded, no pc+4 load, go to REQ.
  - WAIT, no response: go to DRAIN.
  - HOLD: id_valid forced 0 combinationally. The entry is discarded even if id_ready=1, which is not counted as a handshake. Go to REQ.
  - Redirect in DRAIN: the PC is loaded and DRAIN continues.
  - Redirect in IDLE: the PC is loaded and the FSM goes to REQ.
- Only one request is ever outstanding. imem_req_valid stays stable until accepted unless a redirect occurs.
- id_instr, id_pc and id_fault are stable while id_valid=1 and id_ready=0.

Optional Feature:
- Macro: IFETCH_FAULT_EN.
- Defined:
  - In REQ, if pc[1:0]!=0, no request is issued. Go directly to HOLD with id_fault=1, id_instr=0, id_pc=pc.
  - In WAIT, imem_rsp_err=1 sets id_fault=1 and id_instr=0.
  - In both fault cases pc_load=0 (the PC does not advance), so a trap redirect is expected.
- Undefined:
  - id_fault is tied to 0 and imem_rsp_err is ignored.
  - imem_req_addr = {pc[XLEN-1:2],2'b00}.
  - No misalignment check.

Test Plan:
- Reset, pc=0, memory with 0-cycle ready and 1-cycle response returning 0x00500093, id_ready=1 -> request addr 0x0; id_valid with id_instr=0x00500093, id_pc=0; pc_load with next_pc=4. Repeat for 4 back-to-back fetches at addresses 0, 4, 8, 12.
- id_ready held 0 for 5 cycles in HOLD -> id_valid stays 1, outputs stable, no new imem_req_valid. Release -> request for pc+4.
- Redirect to 0x100 in WAIT with the response delayed 3 cycles -> DRAIN discards response 0xDEADBEEF; next request addr 0x100; id_valid never asserted for 0xDEADBEEF.
- Redirect to 0x200 in the same cycle as imem_rsp_valid -> no pc+4 load, next_pc=0x200, response dropped, next request addr 0x200.
- areset pulsed low while in WAIT -> all outputs 0 immediately (asynchronously). Fetch restarts at pc=0 two cycles after release (IDLE then REQ).
- With IFETCH_FAULT_EN: pc=0x6 -> no imem_req_valid; id_valid=1, id_fault=1, id_pc=6, pc_load=0. Separately, imem_rsp_err=1 -> id_fault=1, id_instr=0.
